// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// logic_unit_pipe : registered 8-op bitwise gate unit with zero/ones/parity
//                   flags behind a valid/ready handshake, optional skid buffer
// Revision 1.0
// ----------------------------------------------------------------------------
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int SKID  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic             out_ones,
  output logic             out_parity
);

  // Packet layout: {parity, ones, zero, y}
  localparam int PW = WIDTH + 3;

  logic [WIDTH-1:0] res_y_d;
  logic [PW-1:0]    res_pkt_d;
  logic [PW-1:0]    out_pkt_q;
  logic             out_valid_q;
  logic             accept_d;
  logic             emit_d;

  always_comb begin
    res_y_d = '0;
    case (in_op)
      3'd0:    res_y_d = in_a;
      3'd1:    res_y_d = in_a & in_b;
      3'd2:    res_y_d = in_a | in_b;
      3'd3:    res_y_d = in_a ^ in_b;
      3'd4:    res_y_d = ~in_b;
      3'd5:    res_y_d = ~(in_a & in_b);
      3'd6:    res_y_d = ~(in_a | in_b);
      default: res_y_d = ~(in_a ^ in_b);
    endcase
  end

  assign res_pkt_d = {^res_y_d, &res_y_d, ~|res_y_d, res_y_d};
  assign accept_d  = in_valid & in_ready;
  assign emit_d    = out_valid_q & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_TWO = 2'd2} state_t;

      state_t        state_q;
      logic [PW-1:0] skid_q;
      logic          rdy_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          state_q     <= S_EMPTY;
          out_valid_q <= 1'b0;
          out_pkt_q   <= '0;
          skid_q      <= '0;
          rdy_q       <= 1'b1;
        end else begin
          case (state_q)
            S_EMPTY: begin
              if (accept_d) begin
                out_pkt_q   <= res_pkt_d;
                out_valid_q <= 1'b1;
                state_q     <= S_ONE;
              end
            end
            S_ONE: begin
              if (accept_d && !emit_d) begin
                skid_q  <= res_pkt_d;
                state_q <= S_TWO;
                rdy_q   <= 1'b0;
              end else if (accept_d && emit_d) begin
                out_pkt_q <= res_pkt_d;
              end else if (emit_d) begin
                out_valid_q <= 1'b0;
                state_q     <= S_EMPTY;
              end
            end
            S_TWO: begin
              if (emit_d) begin
                out_pkt_q <= skid_q;
                state_q   <= S_ONE;
                rdy_q     <= 1'b1;
              end
            end
            default: begin
              state_q     <= S_EMPTY;
              out_valid_q <= 1'b0;
              rdy_q       <= 1'b1;
            end
          endcase
        end
      end

      // rdy_q already reflects the post-reset EMPTY state; rst only masks it.
      assign in_ready = rdy_q & ~rst;
    end else begin : g_noskid
      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid_q <= 1'b0;
          out_pkt_q   <= '0;
        end else if (accept_d) begin
          out_pkt_q   <= res_pkt_d;
          out_valid_q <= 1'b1;
        end else if (emit_d) begin
          out_valid_q <= 1'b0;
        end
      end

      assign in_ready = ~rst & (~out_valid_q | out_ready);
    end
  endgenerate

  assign out_valid  = out_valid_q;
  assign out_y      = out_pkt_q[WIDTH-1:0];
  assign out_zero   = out_pkt_q[WIDTH];
  assign out_ones   = out_pkt_q[WIDTH+1];
  assign out_parity = out_pkt_q[WIDTH+2];

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_logic_unit_pipe : scoreboard bench driving SKID=1 and SKID=0 instances
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_logic_unit_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] in_op;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       out_ready;
  logic [10:0] cur_exp;

  logic       in_ready1, out_valid1, out_zero1, out_ones1, out_parity1;
  logic [7:0] out_y1;
  logic       in_ready0, out_valid0, out_zero0, out_ones0, out_parity0;
  logic [7:0] out_y0;

  logic [10:0] q1[$];
  logic [10:0] q0[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(8), .SKID(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid1),
    .out_ready(out_ready), .out_y(out_y1), .out_zero(out_zero1),
    .out_ones(out_ones1), .out_parity(out_parity1)
  );

  logic_unit_pipe #(.WIDTH(8), .SKID(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid0),
    .out_ready(out_ready), .out_y(out_y0), .out_zero(out_zero0),
    .out_ones(out_ones0), .out_parity(out_parity0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] pkt_of(input logic [7:0] y);
    return {^y, &y, ~|y, y};
  endfunction

  function automatic logic [10:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] y;
    case (op)
      3'd0: y = a;
      3'd1: y = a & b;
      3'd2: y = a | b;
      3'd3: y = a ^ b;
      3'd4: y = ~b;
      3'd5: y = ~(a & b);
      3'd6: y = ~(a | b);
      default: y = ~(a ^ b);
    endcase
    return pkt_of(y);
  endfunction

  // Inputs change on the falling edge and hold until the next one.
  task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [10:0] e, input logic ordy);
    @(negedge clk);
    in_valid  = v;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    cur_exp   = e;
    out_ready = ordy;
  endtask

  // Record what each instance accepts at the coming rising edge.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (in_valid && in_ready1) q1.push_back(cur_exp);
      if (in_valid && in_ready0) q0.push_back(cur_exp);
    end
  end

  // Monitors: compare every emitted result and check stall stability.
  logic        stall1 = 1'b0, stall0 = 1'b0;
  logic [10:0] prev1, prev0;

  always @(negedge clk) begin
    logic [10:0] act;
    logic [10:0] e;
    #2;
    act = {out_parity1, out_ones1, out_zero1, out_y1};
    if (rst) begin
      stall1 = 1'b0;
    end else begin
      if (stall1) chk("hold1", {21'd0, act}, {21'd0, prev1});
      if (out_valid1 && out_ready) begin
        if (q1.size() == 0) begin
          chk("extra_out1", 32'd1, 32'd0);
        end else begin
          e = q1.pop_front();
          chk("result1", {21'd0, act}, {21'd0, e});
        end
      end
      stall1 = out_valid1 && !out_ready;
      prev1  = act;
    end
  end

  always @(negedge clk) begin
    logic [10:0] act;
    logic [10:0] e;
    #2;
    act = {out_parity0, out_ones0, out_zero0, out_y0};
    if (rst) begin
      stall0 = 1'b0;
    end else begin
      if (stall0) chk("hold0", {21'd0, act}, {21'd0, prev0});
      if (out_valid0 && out_ready) begin
        if (q0.size() == 0) begin
          chk("extra_out0", 32'd1, 32'd0);
        end else begin
          e = q0.pop_front();
          chk("result0", {21'd0, act}, {21'd0, e});
        end
      end
      stall0 = out_valid0 && !out_ready;
      prev0  = act;
    end
  end

  logic [7:0] sweep[8];

  initial begin
    sweep = '{8'hCA, 8'h48, 8'hDE, 8'h96, 8'hA3, 8'hB7, 8'h21, 8'h69};
    rst = 1'b1; in_valid = 1'b1; in_op = 3'd0; in_a = 8'h55; in_b = 8'h0F;
    cur_exp = '0; out_ready = 1'b1;

    // Reset with in_valid held high
    repeat (2) @(posedge clk);
    @(negedge clk); #3;
    chk("rst_valid1", {31'd0, out_valid1}, 32'd0);
    chk("rst_pkt1", {21'd0, out_parity1, out_ones1, out_zero1, out_y1}, 32'd0);
    chk("rst_ready1", {31'd0, in_ready1}, 32'd0);
    chk("rst_valid0", {31'd0, out_valid0}, 32'd0);
    chk("rst_pkt0", {21'd0, out_parity0, out_ones0, out_zero0, out_y0}, 32'd0);
    chk("rst_ready0", {31'd0, in_ready0}, 32'd0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("post_rst_ready1", {31'd0, in_ready1}, 32'd1);
    chk("post_rst_ready0", {31'd0, in_ready0}, 32'd1);

    // Op sweep at full throughput
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 3'(k), 8'hCA, 8'h5C, pkt_of(sweep[k]), 1'b1);
      #3;
      chk("sweep_ready1", {31'd0, in_ready1}, 32'd1);
      chk("sweep_ready0", {31'd0, in_ready0}, 32'd1);
    end
    drive(1'b0, 3'd0, 8'h00, 8'h00, '0, 1'b1);
    #3;
    chk("sweep_drained1", q1.size(), 32'd0);
    chk("sweep_drained0", q0.size(), 32'd0);

    // Flag corners
    drive(1'b1, 3'd1, 8'h00, 8'h00, {1'b0, 1'b0, 1'b1, 8'h00}, 1'b1);
    drive(1'b1, 3'd0, 8'hFF, 8'h00, {1'b0, 1'b1, 1'b0, 8'hFF}, 1'b1);
    drive(1'b1, 3'd0, 8'h07, 8'h00, {1'b1, 1'b0, 1'b0, 8'h07}, 1'b1);
    drive(1'b0, 3'd0, 8'h00, 8'h00, '0, 1'b1);
    #3;
    chk("flags_drained1", q1.size(), 32'd0);

    // Back-pressure: skid instance takes two, then stalls
    drive(1'b1, 3'd1, 8'hCA, 8'h5C, pkt_of(8'h48), 1'b0);
    drive(1'b1, 3'd3, 8'hCA, 8'h5C, pkt_of(8'h96), 1'b0);
    drive(1'b1, 3'd2, 8'hCA, 8'h5C, pkt_of(8'hDE), 1'b0);
    #3;
    chk("bp_ready1", {31'd0, in_ready1}, 32'd0);
    chk("bp_valid1", {31'd0, out_valid1}, 32'd1);
    chk("bp_y1", {24'd0, out_y1}, 32'h48);
    drive(1'b1, 3'd2, 8'hCA, 8'h5C, pkt_of(8'hDE), 1'b0);
    #3;
    chk("bp_ready1_b", {31'd0, in_ready1}, 32'd0);
    chk("bp_y1_b", {24'd0, out_y1}, 32'h48);
    chk("bp_count1", q1.size(), 32'd2);
    drive(1'b1, 3'd2, 8'hCA, 8'h5C, pkt_of(8'hDE), 1'b1);
    repeat (4) drive(1'b0, 3'd0, 8'h00, 8'h00, '0, 1'b1);
    #3;
    chk("bp_drained1", q1.size(), 32'd0);
    chk("bp_drained0", q0.size(), 32'd0);

    // Reset while the skid instance holds two entries
    drive(1'b1, 3'd1, 8'hCA, 8'h5C, pkt_of(8'h48), 1'b0);
    drive(1'b1, 3'd3, 8'hCA, 8'h5C, pkt_of(8'h96), 1'b0);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    q1.delete(); q0.delete();
    @(negedge clk);
    rst = 1'b0;
    #3;
    chk("r2_valid1", {31'd0, out_valid1}, 32'd0);
    chk("r2_valid0", {31'd0, out_valid0}, 32'd0);
    chk("r2_ready1", {31'd0, in_ready1}, 32'd1);
    drive(1'b1, 3'd0, 8'h3C, 8'h00, pkt_of(8'h3C), 1'b1);
    drive(1'b0, 3'd0, 8'h00, 8'h00, '0, 1'b1);
    #3;
    chk("r2_first_y1", {24'd0, out_y1}, 32'h3C);
    chk("r2_drained1", q1.size(), 32'd0);

    // Random traffic with random stalls on both instances
    for (int i = 0; i < 1000; i++) begin
      logic [2:0] op;
      logic [7:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = 8'($urandom);
      b  = 8'($urandom);
      drive(1'($urandom_range(0, 1)), op, a, b, model(op, a, b), 1'($urandom_range(0, 1)));
    end
    repeat (6) drive(1'b0, 3'd0, 8'h00, 8'h00, '0, 1'b1);
    #3;
    chk("rand_drained1", q1.size(), 32'd0);
    chk("rand_drained0", q0.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
